// File: rtl/fft_frame_scheduler.sv
// Shares one 16-point FFT core between requesters A and B: round-robin per frame,
// pulses the core reset, streams a frame in, waits for done and streams the tagged result out.
module fft_frame_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int SEQ_LENGTH     = 16,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  s_valid_a,
  input  logic                  s_valid_b,
  input  logic [DATA_WIDTH-1:0] s_real_a,
  input  logic [DATA_WIDTH-1:0] s_img_a,
  input  logic [DATA_WIDTH-1:0] s_real_b,
  input  logic [DATA_WIDTH-1:0] s_img_b,
  output logic                  s_ready_a,
  output logic                  s_ready_b,
  output logic                  grant_a,
  output logic                  grant_b,
  output logic                  fft_reset_n,
  output logic                  fft_valid_in,
  output logic [DATA_WIDTH-1:0] fft_real_in,
  output logic [DATA_WIDTH-1:0] fft_img_in,
  input  logic [DATA_WIDTH-1:0] fft_real_out,
  input  logic [DATA_WIDTH-1:0] fft_img_out,
  input  logic                  fft_done,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_real,
  output logic [DATA_WIDTH-1:0] m_img,
  output logic                  m_id,
  output logic                  m_last,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [2:0]            dbg_state
);

  // Sample handshake: a sample moves when s_valid_x && s_ready_x at a rising edge;
  // s_ready_x is high only for the granted side while loading, s_valid without ready is ignored.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FFT_RST   = 3'd1,
    S_LOAD      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_UNLOAD    = 3'd4
  } state_t;

  localparam int CW   = $clog2(SEQ_LENGTH) + 1;
  localparam int TMAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [CW-1:0] C_LAST     = CW'(SEQ_LENGTH - 1);
  localparam logic [TW-1:0] T_RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [TW-1:0]         r_tcnt;
  logic                  r_last_b;
  logic                  r_grant_a;
  logic                  r_grant_b;
  logic                  r_fft_reset_n;
  logic                  r_fft_valid_in;
  logic [DATA_WIDTH-1:0] r_fft_real_in;
  logic [DATA_WIDTH-1:0] r_fft_img_in;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_real;
  logic [DATA_WIDTH-1:0] r_m_img;
  logic                  r_m_id;
  logic                  r_m_last;
  logic                  r_timeout_err;

  logic w_req_any;
  logic w_pick_b;
  logic w_s_valid;
  logic w_accept;
  logic w_rst_done;
  logic w_load_done;
  logic w_timeout;
  logic w_capture;
  logic w_unload_done;

  // On a tie the side opposite the previous winner is picked.
  assign w_req_any     = req_a | req_b;
  assign w_pick_b      = req_b & (~req_a | ~r_last_b);
  assign w_s_valid     = r_grant_b ? s_valid_b : s_valid_a;
  assign w_accept      = (r_state == S_LOAD) & w_s_valid;
  assign w_rst_done    = (r_state == S_FFT_RST) && (r_tcnt == T_RST_LAST);
  assign w_load_done   = w_accept && (r_cnt == C_LAST);
  assign w_timeout     = (r_state == S_WAIT_DONE) && !fft_done && (r_tcnt == T_TO_LAST);
  assign w_capture     = ((r_state == S_WAIT_DONE) && fft_done) || (r_state == S_UNLOAD);
  assign w_unload_done = (r_state == S_UNLOAD) && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_req_any)     w_next = S_FFT_RST;
      S_FFT_RST:   if (w_rst_done)    w_next = S_LOAD;
      S_LOAD:      if (w_load_done)   w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (fft_done)      w_next = S_UNLOAD;
                   else if (w_timeout) w_next = S_IDLE;
      S_UNLOAD:    if (w_unload_done) w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready_a = (r_state == S_LOAD) & r_grant_a;
    s_ready_b = (r_state == S_LOAD) & r_grant_b;
    busy      = (r_state != S_IDLE);
    dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_tcnt         <= '0;
      r_last_b       <= 1'b1;
      r_grant_a      <= 1'b0;
      r_grant_b      <= 1'b0;
      r_fft_reset_n  <= 1'b0;
      r_fft_valid_in <= 1'b0;
      r_fft_real_in  <= '0;
      r_fft_img_in   <= '0;
      r_m_valid      <= 1'b0;
      r_m_real       <= '0;
      r_m_img        <= '0;
      r_m_id         <= 1'b0;
      r_m_last       <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_fft_reset_n  <= (w_next != S_FFT_RST);
      r_fft_valid_in <= w_accept;
      r_m_valid      <= w_capture;
      r_m_last       <= w_unload_done;
      r_timeout_err  <= w_timeout;

      if (w_accept) begin
        r_fft_real_in <= r_grant_b ? s_real_b : s_real_a;
        r_fft_img_in  <= r_grant_b ? s_img_b  : s_img_a;
      end

      if (w_capture) begin
        r_m_real <= fft_real_out;
        r_m_img  <= fft_img_out;
        r_m_id   <= r_grant_b;
      end

      // Grant is held from FFT_RST through the last capture or an abort.
      if ((r_state == S_IDLE) && w_req_any) begin
        r_grant_a <= ~w_pick_b;
        r_grant_b <= w_pick_b;
        r_last_b  <= w_pick_b;
      end else if (w_next == S_IDLE) begin
        r_grant_a <= 1'b0;
        r_grant_b <= 1'b0;
      end

      case (r_state)
        S_LOAD:      if (w_accept) r_cnt <= w_load_done ? '0 : r_cnt + CW'(1);
        S_WAIT_DONE: r_cnt <= fft_done ? CW'(1) : '0;
        S_UNLOAD:    r_cnt <= w_unload_done ? '0 : r_cnt + CW'(1);
        default:     r_cnt <= '0;
      endcase

      // r_tcnt times the core reset pulse and the done timeout.
      case (r_state)
        S_FFT_RST:   r_tcnt <= w_rst_done ? '0 : r_tcnt + TW'(1);
        S_WAIT_DONE: r_tcnt <= (w_next != S_WAIT_DONE) ? '0 : r_tcnt + TW'(1);
        default:     r_tcnt <= '0;
      endcase
    end
  end

  assign grant_a      = r_grant_a;
  assign grant_b      = r_grant_b;
  assign fft_reset_n  = r_fft_reset_n;
  assign fft_valid_in = r_fft_valid_in;
  assign fft_real_in  = r_fft_real_in;
  assign fft_img_in   = r_fft_img_in;
  assign m_valid      = r_m_valid;
  assign m_real       = r_m_real;
  assign m_img        = r_m_img;
  assign m_id         = r_m_id;
  assign m_last       = r_m_last;
  assign timeout_err  = r_timeout_err;

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Sequences the shared 16-point FFT_top core between two frame requesters, A and B.
- Arbitrates round-robin per frame.
- Pulses the core's active-low reset before each frame, then streams SEQ_LENGTH samples in.
- Waits for done, then forwards SEQ_LENGTH result samples tagged with the requester id.
- Timeout guards against a hung core.
- Sits between producer front-ends and FFT_top.

Parameters:
- DATA_WIDTH, 16, sample width per real/imag component.
- SEQ_LENGTH, 16, samples per frame, in and out.
- RST_CYCLES, 2, cycles fft_reset_n is held low before each frame (min 1).
- TIMEOUT_CYCLES, 1024, max cycles in WAIT_DONE before abort.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_a, req_b  in  1  frame request (level, held until granted)
- s_valid_a, s_valid_b  in  1  sample valid from requester
- s_real_a, s_img_a, s_real_b, s_img_b  in  DATA_WIDTH  requester samples
- s_ready_a, s_ready_b  out  1  sample accepted when valid & ready
- grant_a, grant_b  out  1  one-hot ownership, FFT_RST through UNLOAD
- fft_reset_n  out  1  drives FFT_top reset_n
- fft_valid_in  out  1  drives FFT_top valid_in
- fft_real_in, fft_img_in  out  DATA_WIDTH  drive FFT_top data_in_real/img
- fft_real_out, fft_img_out  in  DATA_WIDTH  from FFT_top data_out_real/img
- fft_done  in  1  from FFT_top done
- m_valid  out  1  result sample valid (no backpressure)
- m_real, m_img  out  DATA_WIDTH  result sample
- m_id  out  1  0=A, 1=B
- m_last  out  1  high with final result sample
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset values (all registered outputs):
  - fft_reset_n=0; all other outputs 0.
  - state=IDLE, counters=0, last_grant=B, so A wins first tie.
  - Reset mid-operation aborts immediately. No m_valid or timeout_err is issued for the aborted frame.
- IDLE:
  - fft_reset_n=1.
  - If any req: pick req_a alone, req_b alone, or on both the one opposite last_grant.
  - Next cycle: grant set, last_grant updated, enter FFT_RST.
  - Requests are sampled only in IDLE.
- FFT_RST:
  - fft_reset_n=0 for exactly RST_CYCLES cycles, then LOAD.
  - fft_reset_n=1 from LOAD onward.
- LOAD:
  - s_ready of the granted side = 1; the other side's s_ready stays 0.
  - Each accepted sample appears on fft_real_in/fft_img_in with fft_valid_in=1 one cycle later (1-cycle latency).
  - s_valid gaps give fft_valid_in=0 in the corresponding cycle.
  - After the SEQ_LENGTH-th accept: s_ready drops the next cycle, enter WAIT_DONE.
  - The last fft_valid_in pulse is still issued.
- WAIT_DONE:
  - fft_valid_in=0; timeout counter increments each cycle.
  - fft_done=1 → UNLOAD. The capture cycle is the cycle fft_done is first sampled high.
  - Counter reaches TIMEOUT_CYCLES-1 without done: timeout_err pulses 1 cycle, then FFT_RST-free abort to IDLE. Grant drops, no m_valid.
  - fft_done high in the same cycle as timeout expiry: done wins.
- UNLOAD:
  - Captures fft_real_out/fft_img_out on SEQ_LENGTH consecutive cycles, starting with the capture cycle.
  - Each appears on m_real/m_img with m_valid=1 one cycle later.
  - m_id = granted side; m_last on the SEQ_LENGTH-th.
  - fft_done deasserting during UNLOAD is ignored.
  - After last capture → IDLE; grant drops the same cycle m_last is output.
- Counters are log2(SEQ_LENGTH)+1 bits; no wrap within a frame.
- Data passes through unmodified, no arithmetic.
- grant_a & grant_b is never 1.
- A requester dropping req after grant does not abort the frame.
- s_valid with s_ready=0 is ignored.

Test Plan:
- Single frame A:
  - Stimulus: req_a, 16 samples real=img=128, fft_done forced 5 cycles after last fft_valid_in; model returns k.
  - Required: fft_reset_n low exactly 2 cycles; 16 fft_valid_in pulses of 128/128; 16 m_valid with values 0..15, m_id=0, m_last on the 16th; busy then 0.
- Simultaneous req_a and req_b from reset:
  - Required: A is served first, then B, then A again if both stay asserted. grant is never both 1.
- LOAD with s_valid gaps (pattern 1,0,0,1…):
  - Required: fft_valid_in mirrors the accepts with 1-cycle delay; WAIT_DONE is entered only after 16 accepts; B's s_ready stays 0 throughout.
- fft_done never asserted, TIMEOUT_CYCLES=32:
  - Required: timeout_err is a single pulse 32 cycles into WAIT_DONE; no m_valid; state returns to IDLE and the next req_b is served normally.
- reset asserted mid-UNLOAD (after 7 outputs):
  - Required: next cycle all outputs 0 and fft_reset_n=0; no further m_valid; after release, req_a (not B) wins the first tie.
- fft_done coincident with timeout expiry cycle:
  - Required: UNLOAD proceeds, no timeout_err, 16 outputs delivered.
